// File: rtl/reg_file_mp.sv
// Two-read / two-write register file with optional bypass and zero register,
// plus a single shadow bank for one-cycle snapshot and restore.
module reg_file_mp #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int BYPASS   = 0,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_b,
  input  logic              save,
  input  logic              restore,
  output logic              shadow_valid,
  output logic              collision
);

  logic [DATA_W-1:0] mem_q    [DEPTH];
  logic [DATA_W-1:0] mem_d    [DEPTH];
  logic [DATA_W-1:0] shadow_q [DEPTH];
  logic [DATA_W-1:0] shadow_d [DEPTH];
  logic              shadow_valid_q, shadow_valid_d;
  logic              collision_q, collision_d;
  logic              do_restore, do_save;
  logic              wr_a_ok, wr_b_ok;

  assign do_restore = restore & shadow_valid_q;
  assign do_save    = save & ~do_restore;
  assign wr_a_ok    = we_a & ~((ZERO_REG != 0) && (wa_a == '0));
  assign wr_b_ok    = we_b & ~((ZERO_REG != 0) && (wa_b == '0));

  // Restored image first, then this cycle's writes on top; B applied last wins.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i]    = do_restore ? shadow_q[i] : mem_q[i];
      shadow_d[i] = do_save ? mem_q[i] : shadow_q[i];
    end
    if (wr_a_ok) mem_d[wa_a] = wd_a;
    if (wr_b_ok) mem_d[wa_b] = wd_b;
    shadow_valid_d = shadow_valid_q | do_save;
    collision_d    = we_a & we_b & (wa_a == wa_b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      shadow_valid_q <= 1'b0;
      collision_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]    <= mem_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      shadow_valid_q <= shadow_valid_d;
      collision_q    <= collision_d;
    end
  end

  always_comb begin
    rd1 = mem_q[ra1];
    if (BYPASS != 0) begin
      if (we_a && (wa_a == ra1)) rd1 = wd_a;
      if (we_b && (wa_b == ra1)) rd1 = wd_b;
    end
    if ((ZERO_REG != 0) && (ra1 == '0)) rd1 = '0;
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if (BYPASS != 0) begin
      if (we_a && (wa_a == ra2)) rd2 = wd_a;
      if (we_b && (wa_b == ra2)) rd2 = wd_b;
    end
    if ((ZERO_REG != 0) && (ra2 == '0)) rd2 = '0;
  end

  assign shadow_valid = shadow_valid_q;
  assign collision    = collision_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: plain instance and a BYPASS+ZERO_REG instance
// share stimulus and are compared against an array-based reference model.
module tb_reg_file_mp;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ra1, ra2, wa_a, wa_b;
  logic [7:0] wd_a, wd_b;
  logic       we_a, we_b, save, restore;
  logic [7:0] rd1_p, rd2_p, rd1_z, rd2_z;
  logic       sv_p, sv_z, col_p, col_z;

  int n_chk  = 0;
  int n_pass = 0;

  int  m  [2][16];
  int  sh [2][16];
  bit  msv[2];
  bit  mcol[2];

  always #5 clk = ~clk;

  reg_file_mp u_plain (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_p), .rd2(rd2_p),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .save(save), .restore(restore),
    .shadow_valid(sv_p), .collision(col_p)
  );

  reg_file_mp #(.BYPASS(1), .ZERO_REG(1)) u_zb (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_z), .rd2(rd2_z),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .save(save), .restore(restore),
    .shadow_valid(sv_z), .collision(col_z)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // k=1 is the bypass + zero-register configuration
  function automatic int exp_rd(input int k, input int ra);
    if (k == 1) begin
      if (ra == 0) return 0;
      if (we_b && wa_b == ra) return wd_b;
      if (we_a && wa_a == ra) return wd_a;
    end
    return m[k][ra];
  endfunction

  function automatic void model_step();
    int old[16];
    bit rs;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int i = 0; i < 16; i++) begin
          m[k][i] = 0;
          sh[k][i] = 0;
        end
        msv[k]  = 0;
        mcol[k] = 0;
      end else begin
        rs = restore && msv[k];
        for (int i = 0; i < 16; i++) old[i] = m[k][i];
        if (rs)
          for (int i = 0; i < 16; i++) m[k][i] = sh[k][i];
        if (we_a && !(k == 1 && wa_a == 0)) m[k][wa_a] = wd_a;
        if (we_b && !(k == 1 && wa_b == 0)) m[k][wa_b] = wd_b;
        if (save && !rs) begin
          for (int i = 0; i < 16; i++) sh[k][i] = old[i];
          msv[k] = 1;
        end
        mcol[k] = we_a && we_b && (wa_a == wa_b);
      end
    end
  endfunction

  task automatic tick();
    #1;
    check("rd1_plain", rd1_p, exp_rd(0, ra1));
    check("rd2_plain", rd2_p, exp_rd(0, ra2));
    check("rd1_zb", rd1_z, exp_rd(1, ra1));
    check("rd2_zb", rd2_z, exp_rd(1, ra2));
    @(posedge clk);
    model_step();
    #1;
    check("sv_plain", sv_p, msv[0]);
    check("sv_zb", sv_z, msv[1]);
    check("col_plain", col_p, mcol[0]);
    check("col_zb", col_z, mcol[1]);
  endtask

  task automatic idle();
    reset = 0; we_a = 0; we_b = 0; save = 0; restore = 0;
  endtask

  task automatic wr_a(input int a, input int d);
    idle(); we_a = 1; wa_a = 4'(a); wd_a = 8'(d);
  endtask

  initial begin
    idle();
    ra1 = 0; ra2 = 0; wa_a = 0; wa_b = 0; wd_a = 0; wd_b = 0;
    @(posedge clk); #1;
    reset = 1;
    tick();
    idle();
    for (int a = 0; a < 16; a++) begin
      ra1 = 4'(a); ra2 = 4'(15 - a);
      tick();
      check("reset_rd1", rd1_p, 0);
    end

    for (int i = 0; i < 8; i++) begin
      wr_a(2 * i + 1, 2 * i + 2);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      ra1 = 4'(4 * i + 1); ra2 = 4'(4 * i + 3);
      #1;
      check("pair_rd1", rd1_p, 4 * i + 2);
      check("pair_rd2", rd2_p, 4 * i + 4);
      tick();
    end

    wr_a(5, 8'h11); we_b = 1; wa_b = 5; wd_b = 8'h22;
    tick();
    check("col_pulse", col_p, 1);
    idle(); ra1 = 5;
    tick();
    check("col_drop", col_p, 0);
    check("coll_data", rd1_p, 8'h22);

    wr_a(4, 8'h3C); ra1 = 4;
    #1;
    check("bypass_zb", rd1_z, 8'h3C);
    check("nobypass", rd1_p, 0);
    tick();
    idle();
    tick();
    check("after_edge", rd1_p, 8'h3C);

    wr_a(2, 8'h07); tick();
    wr_a(2, 8'h55); save = 1; tick();
    wr_a(2, 8'h99); tick();
    idle(); restore = 1; we_b = 1; wa_b = 3; wd_b = 8'hAA; tick();
    idle(); ra1 = 2; ra2 = 3;
    tick();
    check("restore_a2", rd1_p, 8'h07);
    check("restore_a3", rd2_p, 8'hAA);
    check("sv_stays", sv_p, 1);

    wr_a(0, 8'hFF); ra1 = 0; tick();
    idle(); tick();
    check("zero_reg", rd1_z, 0);
    check("plain_r0", rd1_p, 8'hFF);

    idle(); save = 1; reset = 1; tick();
    check("rst_save", sv_p, 0);
    wr_a(6, 8'h66); tick();
    idle(); restore = 1; ra1 = 6; tick();
    check("restore_nosv", rd1_p, 8'h66);
    idle(); save = 1; tick();
    wr_a(6, 8'h67); tick();
    idle(); save = 1; restore = 1; tick();
    check("sr_rd", rd1_p, 8'h66);
    wr_a(6, 8'h68); tick();
    idle(); restore = 1; tick();
    check("sr_img", rd1_p, 8'h66);

    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow  = ($urandom_range(0, 1) == 1);
      reset   = ($urandom_range(0, 49) == 0);
      save    = ($urandom_range(0, 7) == 0);
      restore = ($urandom_range(0, 7) == 0);
      we_a    = 1'($urandom);
      we_b    = 1'($urandom);
      wa_a    = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      wa_b    = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      ra1     = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
      ra2     = 4'($urandom);
      wd_a    = 8'($urandom);
      wd_b    = 8'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file: the next generation of the 16x8 single-write register file. It has configurable width and depth, two asynchronous read ports, and two write ports with a defined collision priority. It also adds optional write-to-read bypass, an optional hardwired zero register, and a one-cycle shadow snapshot/restore of the whole array. It sits in the datapath between the decode stage (read addresses) and the ALU/writeback stages (two write ports).

## Interface
Parameters:
- DATA_W, 8, bits per register
- DEPTH, 16, number of registers (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)
- BYPASS, 0, 1 = same-cycle write data forwarded to read ports
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- ra1  in  ADDR_W  read address, port 1
- ra2  in  ADDR_W  read address, port 2
- rd1  out  DATA_W  read data, port 1 (combinational)
- rd2  out  DATA_W  read data, port 2 (combinational)
- we_a  in  1  write enable, port A
- wa_a  in  ADDR_W  write address, port A
- wd_a  in  DATA_W  write data, port A
- we_b  in  1  write enable, port B
- wa_b  in  ADDR_W  write address, port B
- wd_b  in  DATA_W  write data, port B
- save  in  1  copy entire array into shadow bank
- restore  in  1  copy shadow bank back into array
- shadow_valid  out  1  shadow holds a saved image
- collision  out  1  registered pulse: previous cycle had both ports writing the same address

## Operation
- Reads: rd1 = array[ra1], rd2 = array[ra2], asynchronous. With ZERO_REG=1, address 0 reads 0.
- BYPASS=1: if a write to a read address is enabled this cycle, that read port returns the winning write data before the edge. Port B beats port A. ZERO_REG takes precedence over bypass.
- Writes: on the edge, array[wa_a] <= wd_a if we_a, and array[wa_b] <= wd_b if we_b.
  - Same address on both ports: B's data is stored and collision = 1 for the next cycle.
  - With ZERO_REG=1, writes to address 0 are dropped, but collision is still reported.
- save: on the edge, shadow <= array contents **before** this cycle's writes; shadow_valid <= 1.
- restore (only when shadow_valid=1): on the edge, array <= shadow, then this cycle's writes are applied on top (writes win per address). shadow_valid is unchanged. restore with shadow_valid=0 is ignored.
- save and restore together: restore takes effect; save is ignored.
- reset: overrides everything. Array and shadow clear to 0; shadow_valid = 0; collision = 0.

## Timing
- Reset values: rd1 = rd2 = 0 for any address; shadow_valid = 0; collision = 0.
- Write-to-read latency: 1 cycle (0 with BYPASS=1).
- save→shadow_valid: 1 cycle.
- restore→restored data visible on rd: 1 cycle.
- collision is high for exactly one cycle per colliding write cycle; back-to-back collisions hold it high.
- Address range is fully used because DEPTH is a power of two, so there is no out-of-range case.
- Reset asserted mid-sequence (e.g. on the cycle of a save) discards that save and restore.

## Test plan
- Reset, then read all addresses → rd1 = rd2 = 0, shadow_valid = 0, collision = 0.
- Port A writes odd addresses 1,3,…,15 with data 2,4,…,16, one per cycle; then read pairs (1,3), (5,7), (9,11), (13,15) → 2/4, 6/8, 10/12, 14/16.
- Same cycle: we_a to addr 5 with 0x11, we_b to addr 5 with 0x22 → addr 5 reads 0x22; collision = 1 for exactly one cycle.
- BYPASS=1: ra1 = 4, write 0x3C to addr 4 → rd1 = 0x3C in the same cycle. BYPASS=0: rd1 keeps the old value until after the edge.
- save with addr 2 = 0x07 while port A writes 0x55 to addr 2; write addr 2 = 0x99; then restore while port B writes 0xAA to addr 3 → addr 2 = 0x07, addr 3 = 0xAA; shadow_valid stays 1.
- ZERO_REG=1: write 0xFF to addr 0 → rd reads 0. restore before any save → array unchanged. save+restore together after a save → restore applied, shadow image unchanged.
